conv_enc_packer: RTL and testbench

Rate-1/2, constraint-length-3 convolutional encoder that accepts data bytes over a valid/ready handshake and produces one 16-bit codeword of 8 encoded symbol pairs per byte. It sits directly upstream of the parallel-to-serial stage in the Viterbi test chain.
- Output side: pulses `load_o` with the codeword.
- Holds off the next byte until the serializer has returned all 8 `ser_valid_i` strobes, so no codeword is dropped while the serializer is busy.

---
 rtl/conv_enc_packer.sv | 126 ++++++++++++
 tb/tb_conv_enc_packer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/conv_enc_packer.sv
// Rate-1/2, K=3 convolutional encoder: packs 8 symbol pairs per byte into a 16-bit codeword and waits for the serializer to drain it.
// Optional macro CONV_ENC_BYTE_TERM_EN: clear encoder memory at every byte acceptance.
module conv_enc_packer #(
    parameter logic [2:0] G0 = 3'b111,
    parameter logic [2:0] G1 = 3'b101
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  in_data_i,
    input  logic        in_sop_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    output logic        load_o,
    output logic [15:0] data_o,
    input  logic        ser_valid_i,
    output logic        busy_o
);

    typedef enum logic [1:0] {IDLE, ENC, LOAD, DRAIN} state_t;

    state_t      state_q, state_d;
    logic [7:0]  byte_q, byte_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [3:0]  strb_cnt_q, strb_cnt_d;
    logic        s1_q, s1_d;
    logic        s2_q, s2_d;
    logic [13:0] cw_q, cw_d;
    logic [15:0] data_q, data_d;
    logic [1:0]  pair;
    logic        clr_mem;

    // Tap order is {d, s1, s2}, matching bits [2:0] of the generators.
    function automatic logic [1:0] enc_pair(input logic d, input logic s1, input logic s2);
        logic [2:0] taps;
        taps = {d, s1, s2};
        return {^(taps & G0), ^(taps & G1)};
    endfunction

`ifdef CONV_ENC_BYTE_TERM_EN
    assign clr_mem = 1'b1;
`else
    assign clr_mem = in_sop_i;
`endif

    assign pair = enc_pair(byte_q[7], s1_q, s2_q);

    always_comb begin
        state_d    = state_q;
        byte_d     = byte_q;
        bit_cnt_d  = bit_cnt_q;
        strb_cnt_d = strb_cnt_q;
        s1_d       = s1_q;
        s2_d       = s2_q;
        cw_d       = cw_q;
        data_d     = data_q;
        case (state_q)
            IDLE: begin
                if (in_valid_i) begin
                    byte_d    = in_data_i;
                    bit_cnt_d = 4'd8;
                    cw_d      = '0;
                    if (clr_mem) begin
                        s1_d = 1'b0;
                        s2_d = 1'b0;
                    end
                    state_d = ENC;
                end
            end
            ENC: begin
                cw_d      = {cw_q[11:0], pair};
                byte_d    = {byte_q[6:0], 1'b0};
                s2_d      = s1_q;
                s1_d      = byte_q[7];
                bit_cnt_d = bit_cnt_q - 4'd1;
                // Last bit: the finished codeword goes straight to the output register.
                if (bit_cnt_q == 4'd1) begin
                    data_d  = {cw_q, pair};
                    state_d = LOAD;
                end
            end
            LOAD: begin
                strb_cnt_d = 4'd0;
                state_d    = DRAIN;
            end
            DRAIN: begin
                if (ser_valid_i) begin
                    if (strb_cnt_q == 4'd7) begin
                        strb_cnt_d = 4'd0;
                        state_d    = IDLE;
                    end else begin
                        strb_cnt_d = strb_cnt_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            byte_q     <= '0;
            bit_cnt_q  <= '0;
            strb_cnt_q <= '0;
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            cw_q       <= '0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            byte_q     <= byte_d;
            bit_cnt_q  <= bit_cnt_d;
            strb_cnt_q <= strb_cnt_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            cw_q       <= cw_d;
            data_q     <= data_d;
        end
    end

    assign in_ready_o = (state_q == IDLE);
    assign load_o     = (state_q == LOAD);
    assign busy_o     = (state_q != IDLE);
    assign data_o     = data_q;

endmodule

// File: tb/tb_conv_enc_packer.sv
// Directed bench for conv_enc_packer: hand-computed codewords, handshake timing, drain and reset behaviour.
module tb_conv_enc_packer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  in_data_i = '0;
    logic        in_sop_i = 1'b0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic        load_o;
    logic [15:0] data_o;
    logic        ser_valid_i = 1'b0;
    logic        busy_o;

    int checks = 0;
    int failures = 0;
    int acc_cnt = 0;

    conv_enc_packer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data_i  (in_data_i),
        .in_sop_i   (in_sop_i),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .load_o     (load_o),
        .data_o     (data_o),
        .ser_valid_i(ser_valid_i),
        .busy_o     (busy_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (in_valid_i && in_ready_o) acc_cnt <= acc_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Count edges from the current point (just after acceptance) to load_o; expect 8.
    task automatic wait_load(input logic [15:0] exp, input string tag);
        int n = 0;
        while (load_o !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_latency"}, n, 8);
        chk({tag, "_data"}, data_o, exp);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic sop, input int early,
                             input logic [15:0] exp, input string tag);
        int n = 0;
        while (in_ready_o !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_ready_wait"}, (n < 50), 1);
        in_data_i  = b;
        in_sop_i   = sop;
        in_valid_i = 1'b1;
        @(posedge clk); #1;
        in_valid_i = 1'b0;
        in_sop_i   = 1'b0;
        chk({tag, "_busy"}, busy_o, 1);
        chk({tag, "_not_ready"}, in_ready_o, 0);
        n = 0;
        while (load_o !== 1'b1 && n < 20) begin
            ser_valid_i = (n < early);
            @(posedge clk); #1;
            n++;
        end
        ser_valid_i = 1'b0;
        chk({tag, "_latency"}, n, 8);
        chk({tag, "_data"}, data_o, exp);
    endtask

    // Called in the LOAD cycle; returns just after the edge that samples the 8th strobe.
    task automatic drain(input int gap, input logic [15:0] exp, input string tag);
        @(posedge clk); #1;
        ser_valid_i = 1'b0;
        chk({tag, "_load_pulse_end"}, load_o, 0);
        chk({tag, "_data_hold"}, data_o, exp);
        for (int k = 0; k < 8; k++) begin
            ser_valid_i = 1'b1;
            @(posedge clk); #1;
            ser_valid_i = 1'b0;
            if (k < 7) chk({tag, "_drain_not_ready"}, in_ready_o, 0);
            else       chk({tag, "_drain_ready"}, in_ready_o, 1);
            if (k < 7) begin
                for (int g = 0; g < gap; g++) begin
                    @(posedge clk); #1;
                    chk({tag, "_gap_ready"}, in_ready_o, 0);
                    chk({tag, "_gap_no_load"}, load_o, 0);
                end
            end
        end
    endtask

    initial begin
        int acc0;
        logic [15:0] exp3;
`ifdef CONV_ENC_BYTE_TERM_EN
        exp3 = 16'h0000;
`else
        exp3 = 16'hB000;
`endif
        #12;
        chk("rst_ready", in_ready_o, 1);
        chk("rst_load", load_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_data", data_o, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        send_byte(8'h80, 1'b1, 0, 16'hEC00, "b80");
        drain(0, 16'hEC00, "b80");

        // A strobe in the LOAD cycle must not count towards the 8.
        send_byte(8'hFF, 1'b1, 0, 16'hDAAA, "bFF");
        ser_valid_i = 1'b1;
        drain(1, 16'hDAAA, "bFF");

        send_byte(8'h80, 1'b1, 0, 16'hEC00, "seq0");
        drain(0, 16'hEC00, "seq0");
        send_byte(8'h01, 1'b0, 0, 16'h0003, "seq1");
        drain(0, 16'h0003, "seq1");
        send_byte(8'h00, 1'b0, 0, exp3, "seq2");
        drain(0, exp3, "seq2");

        // Strobes during ENC are ignored.
        send_byte(8'hFF, 1'b1, 5, 16'hDAAA, "early");
        drain(0, 16'hDAAA, "early");

        // Continuous valid with slow serializer (strobes 17 cycles apart).
        acc0 = acc_cnt;
        in_data_i  = 8'h80;
        in_sop_i   = 1'b1;
        in_valid_i = 1'b1;
        @(posedge clk); #1;
        wait_load(16'hEC00, "strm0");
        drain(16, 16'hEC00, "strm0");
        chk("strm_acc1", acc_cnt - acc0, 1);
        @(posedge clk); #1;
        wait_load(16'hEC00, "strm1");
        drain(16, 16'hEC00, "strm1");
        in_valid_i = 1'b0;
        in_sop_i   = 1'b0;
        chk("strm_acc2", acc_cnt - acc0, 2);

        // Asynchronous reset in the middle of ENC.
        in_data_i  = 8'hFF;
        in_sop_i   = 1'b1;
        in_valid_i = 1'b1;
        @(posedge clk); #1;
        in_valid_i = 1'b0;
        in_sop_i   = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_load", load_o, 0);
        chk("arst_busy", busy_o, 0);
        chk("arst_data", data_o, 16'h0000);
        chk("arst_ready", in_ready_o, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        send_byte(8'h80, 1'b1, 0, 16'hEC00, "post_rst");
        drain(0, 16'hEC00, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
